// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART types and constants. The receiver, the receive FIFO and the
// future transmit FIFO all use these definitions, so they agree on byte width
// and default FIFO sizing.
//
// Contents:
//   UART_DATA_W           byte width shared with the receiver
//   UART_FIFO_DEPTH_LOG2  default log2 entry count of a UART FIFO
//   UART_FIFO_AF_LEVEL    default almost-full threshold (occupancy)
//   uart_byte_t           one UART byte
//   uart_fifo_flags_t     registered FIFO status flags
//   uart_fifo_flags()     flag decode from an occupancy value
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int UART_FIFO_DEPTH_LOG2 = 4;
  localparam int UART_FIFO_AF_LEVEL   = 12;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_full;
  } uart_fifo_flags_t;

  localparam uart_fifo_flags_t UART_FIFO_FLAGS_RST = '{
    empty:       1'b1,
    full:        1'b0,
    almost_full: 1'b0
  };

  // Flags are decoded from the next-state occupancy so that the registered
  // copies line up with the registered count.
  function automatic uart_fifo_flags_t uart_fifo_flags(
    input int unsigned count,
    input int unsigned depth,
    input int unsigned af_level
  );
    uart_fifo_flags_t f;
    f.empty       = (count == 0);
    f.full        = (count == depth);
    f.almost_full = (count >= af_level);
    return f;
  endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// -----------------------------------------------------------------------------
// uart_fifo_ram
// Simple dual-port storage array for UART FIFOs: one synchronous write port
// and one read port. The read port is either registered (1-cycle latency,
// output register reset to zero) or asynchronous, chosen by REG_RD. The
// storage array itself is never reset.
//
// Parameters:
//   DATA_W  entry width
//   ADDR_W  address width; the array holds 2**ADDR_W entries
//   REG_RD  1: registered read updated when re is high; 0: async read
//
// Ports:
//   clk    in   clock
//   rst_n  in   async active-low reset (read register only)
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   re     in   read enable (registered read only)
//   raddr  in   read address
//   rdata  out  read data
// -----------------------------------------------------------------------------
module uart_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter bit REG_RD = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  generate
    if (REG_RD) begin : g_reg_rd
      logic [DATA_W-1:0] rdata_q;
      logic [DATA_W-1:0] rdata_d;

      // Holds its last value between reads. A read and a write to the same
      // address in one cycle returns the old contents.
      always_comb begin
        rdata_d = rdata_q;
        if (re) begin
          rdata_d = mem_q[raddr];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else begin
          rdata_q <= rdata_d;
        end
      end

      assign rdata = rdata_q;
    end else begin : g_async_rd
      // Async read has no enable and no state to reset.
      logic unused_rd_ctrl;
      assign unused_rd_ctrl = &{1'b0, re, rst_n};
      assign rdata          = mem_q[raddr];
    end
  endgenerate

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer behind the UART receiver. Every byte presented on the
// receiver's done tick is written into a circular FIFO; the consumer drains
// it through a read handshake. Provides registered empty/full/almost_full
// flags, an explicit occupancy count and a sticky overrun indicator.
//
// Build option:
//   UART_RX_FIFO_FWFT_EN  defined: first-word-fall-through, dout shows the
//                         head entry whenever empty is low (don't-care while
//                         empty). Undefined: dout is registered and updates
//                         on the clock edge that completes a pop.
//
// Parameters:
//   DATA_W      byte width (matches receiver output)
//   DEPTH_LOG2  log2 of entry count
//   AF_LEVEL    occupancy at or above which almost_full asserts
//
// Ports:
//   clk          in   system clock
//   reset        in   async active-low reset
//   din          in   byte from receiver
//   wr_tick      in   one-cycle write strobe from receiver
//   rd_en        in   consumer pop request
//   dout         out  read data
//   empty        out  FIFO holds no entries
//   full         out  FIFO holds 2**DEPTH_LOG2 entries
//   almost_full  out  count >= AF_LEVEL
//   count        out  current occupancy
//   overrun      out  sticky: a write arrived while full and was dropped
//   clr_overrun  in   one-cycle clear of overrun
//
// Read handshake: empty low is "valid", rd_en is "ready"; an entry is popped
// on a clock edge where rd_en is high and empty is low. rd_en while empty is
// ignored. The write side has no backpressure: a write while full with no
// pop in the same cycle is dropped and flagged via overrun.
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int          DATA_W     = UART_DATA_W,
  parameter int          DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
  parameter int unsigned AF_LEVEL   = UART_FIFO_AF_LEVEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     din,
  input  logic                  wr_tick,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     dout,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

`ifdef UART_RX_FIFO_FWFT_EN
  localparam bit REG_RD = 1'b0;
`else
  localparam bit REG_RD = 1'b1;
`endif

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   cnt_t;

  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  uart_fifo_flags_t flags_q, flags_d;
  logic             overrun_q, overrun_d;

  logic pop;
  logic wr_accept;
  logic overrun_event;

  always_comb begin
    pop           = rd_en && !flags_q.empty;
    // A pop in the same cycle frees a slot, so a write to a full FIFO is
    // still accepted when the consumer is reading.
    wr_accept     = wr_tick && (!flags_q.full || pop);
    overrun_event = wr_tick && flags_q.full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    // Pointers are DEPTH_LOG2 bits wide and wrap modulo depth on overflow.
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase

    flags_d = uart_fifo_flags(32'(count_d), DEPTH, AF_LEVEL);

    // Set has priority over clear so a coincident overrun is never lost.
    overrun_d = overrun_q;
    if (clr_overrun) begin
      overrun_d = 1'b0;
    end
    if (overrun_event) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      flags_q   <= UART_FIFO_FLAGS_RST;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      flags_q   <= flags_d;
      overrun_q <= overrun_d;
    end
  end

  // Registered read uses the current rd_ptr so the popped entry lands on
  // dout at the same edge that advances the pointer. In FWFT mode the async
  // read shows whatever entry rd_ptr points at.
  uart_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2),
    .REG_RD (REG_RD)
  ) u_ram (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr_accept),
    .waddr (wr_ptr_q),
    .wdata (din),
    .re    (pop),
    .raddr (rd_ptr_q),
    .rdata (dout)
  );

  assign empty       = flags_q.empty;
  assign full        = flags_q.full;
  assign almost_full = flags_q.almost_full;
  assign count       = count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DW  = 8;
  localparam int DL2 = 4;
  localparam int AF  = 12;
  localparam int NV  = 13;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            reset = 1'b0;
  uart_byte_t      din = '0;
  logic            wr_tick = 1'b0;
  logic            rd_en = 1'b0;
  logic            clr_overrun = 1'b0;
  uart_byte_t      dout;
  logic            empty;
  logic            full;
  logic            almost_full;
  logic [DL2:0]    count;
  logic            overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DATA_W     (DW),
    .DEPTH_LOG2 (DL2),
    .AF_LEVEL   (AF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .wr_tick     (wr_tick),
    .rd_en       (rd_en),
    .dout        (dout),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  // ---------------- scoreboard state ----------------
  int              checks = 0;
  int              errors = 0;
  logic [DW-1:0]   exp_q[$];
  uart_byte_t      pre_dout;
  logic            pre_empty;

  typedef struct {
    logic        wr;
    logic [7:0]  d;
    logic        rd;
    logic        clr;
    logic        e_empty;
    logic        e_full;
    logic        e_af;
    logic [4:0]  e_count;
    logic        e_ovr;
    logic        chk_dout;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t vecs[NV];

  // ---------------- checker / driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_status(input string name, input logic e_empty, input logic e_full,
                            input logic e_af, input logic [4:0] e_count, input logic e_ovr);
    chk({name, ".empty"},       32'(empty),       32'(e_empty));
    chk({name, ".full"},        32'(full),        32'(e_full));
    chk({name, ".almost_full"}, 32'(almost_full), 32'(e_af));
    chk({name, ".count"},       32'(count),       32'(e_count));
    chk({name, ".overrun"},     32'(overrun),     32'(e_ovr));
  endtask

  // Drive one cycle of inputs at the falling edge, sample the pre-edge dout,
  // let the rising edge consume them, then return inputs to idle.
  task automatic step(input logic wr, input logic [7:0] d, input logic rd, input logic clr);
    @(negedge clk);
    wr_tick     = wr;
    din         = d;
    rd_en       = rd;
    clr_overrun = clr;
    #1;
    pre_dout  = dout;
    pre_empty = empty;
    @(posedge clk);
    #1;
    wr_tick     = 1'b0;
    rd_en       = 1'b0;
    clr_overrun = 1'b0;
  endtask

  // Popped data: registered build shows it after the edge, FWFT before it.
  task automatic chk_pop(input string name, input logic [7:0] exp);
`ifdef UART_RX_FIFO_FWFT_EN
    chk(name, 32'(pre_dout), 32'(exp));
`else
    chk(name, 32'(dout), 32'(exp));
`endif
  endtask

  // Push/pop helpers keeping exp_q in step with the FIFO contents.
  task automatic push(input logic [7:0] d, input string name);
    logic [4:0] c;
    step(1'b1, d, 1'b0, 1'b0);
    exp_q.push_back(d);
    c = 5'(exp_q.size());
    chk_status(name, 1'b0, c == 5'd16, c >= 5'(AF), c, overrun);
  endtask

  task automatic pop_chk(input string name);
    logic [7:0] e;
    logic [4:0] c;
    e = exp_q.pop_front();
    step(1'b0, 8'h00, 1'b1, 1'b0);
    c = 5'(exp_q.size());
    chk_pop({name, ".dout"}, e);
    chk_status(name, c == 5'd0, 1'b0, c >= 5'(AF), c, overrun);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    // Directed vectors: {wr, din, rd, clr, empty, full, af, count, ovr, chk_dout, dout}
    vecs[0]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 8'h00};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, 8'h00};
    vecs[4]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 8'hFF};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 8'hFF};
    vecs[9]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'hFF};
    vecs[10] = '{1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h11};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h11};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 8'h22};

    // Reset state, checked while reset is held low.
    repeat (3) @(negedge clk);
    #1;
    chk_status("reset", 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("reset.dout", 32'(dout), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Table-driven section: idle pops, 3-byte write/drain, write+pop corners.
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].wr, vecs[i].d, vecs[i].rd, vecs[i].clr);
      chk_status($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full,
                 vecs[i].e_af, vecs[i].e_count, vecs[i].e_ovr);
      if (vecs[i].chk_dout) begin
`ifdef UART_RX_FIFO_FWFT_EN
        if (vecs[i].rd && !pre_empty)
          chk($sformatf("vec%0d.dout", i), 32'(pre_dout), 32'(vecs[i].e_dout));
`else
        chk($sformatf("vec%0d.dout", i), 32'(dout), 32'(vecs[i].e_dout));
`endif
      end
    end

    // Fill to full, overflow once, drain in order.
    for (int i = 0; i < 16; i++) push(8'(i), $sformatf("fill%0d", i));
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk_status("overflow", 1'b0, 1'b1, 1'b1, 5'd16, 1'b1);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("drain%0d", i));

    // Overrun is sticky until cleared.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_status("clr_after_drain", 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);

    // Full FIFO with simultaneous write and pop: write accepted, no overrun.
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i), $sformatf("refill%0d", i));
    begin
      logic [7:0] e;
      e = exp_q.pop_front();
      step(1'b1, 8'hC3, 1'b1, 1'b0);
      exp_q.push_back(8'hC3);
      chk_pop("full_wr_rd.dout", e);
      chk_status("full_wr_rd", 1'b0, 1'b1, 1'b1, 5'd16, 1'b0);
    end

    // Overrun, then clear coincident with another overrun: set wins.
    step(1'b1, 8'h99, 1'b0, 1'b0);
    chk_status("ovr_set", 1'b0, 1'b1, 1'b1, 5'd16, 1'b1);
    step(1'b1, 8'h9A, 1'b0, 1'b1);
    chk_status("ovr_set_wins", 1'b0, 1'b1, 1'b1, 5'd16, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_status("ovr_clr", 1'b0, 1'b1, 1'b1, 5'd16, 1'b0);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("drain2_%0d", i));

    // Reset mid-stream with 5 entries held.
    for (int i = 0; i < 5; i++) push(8'h40 + 8'(i), $sformatf("pre_rst%0d", i));
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk_status("mid_reset", 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
`ifndef UART_RX_FIFO_FWFT_EN
    chk("mid_reset.dout", 32'(dout), 32'h0);
`endif
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;

    // Post-reset traffic, then enough pairs to wrap both pointers.
    push(8'h7E, "post_rst_wr");
    pop_chk("post_rst_rd");
    for (int i = 0; i < 20; i++) begin
      push(8'(8'h10 + 8'(i * 7)), $sformatf("wrap_wr%0d", i));
      pop_chk($sformatf("wrap_rd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
